// File: rtl/ip_lcd_queue_ctrl.sv
// Queued HD44780-class character-LCD controller; bus timing derived from FREQ, 8- or 4-bit bus.
// Define LCD_AUTO_WRAP_EN to track the cursor and wrap to the next row after the last column.
module ip_lcd_queue_ctrl #(
    parameter int FREQ       = 50_000_000,
    parameter int BUS_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_ROWS   = 2,
    parameter int NUM_COLS   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [1:0]                   i_func,
    input  logic [7:0]                   i_data,
    input  logic                         i_on_lcd,
    input  logic                         i_lcd_blon,
    output logic [BUS_WIDTH-1:0]         o_LCD_DATA,
    output logic                         o_LCD_E,
    output logic                         o_LCD_RS,
    output logic                         o_LCD_RW,
    output logic                         o_LCD_ON,
    output logic                         o_LCD_BLON,
    output logic                         o_done_lcd,
    output logic                         o_init_done,
    output logic                         o_busy,
    output logic [$clog2(FIFO_DEPTH):0]  o_level
);
    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam logic [31:0] TU   = 32'(FREQ / 1_000_000);
    localparam bit          FOUR = (BUS_WIDTH == 4);
    localparam logic [7:0]  FSET = (FOUR ? 8'h20 : 8'h30) | ((NUM_ROWS > 1) ? 8'h08 : 8'h00);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT, IDLE, FETCH, SETUP, E_HIGH, HOLD, EXEC_WAIT
`ifdef LCD_AUTO_WRAP_EN
        , WRAP
`endif
    } state_t;

    function automatic logic [31:0] us_cycles(input int us);
        return 32'(us) * TU - 32'd1;
    endfunction

    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'(NUM_COLS);
            default: return 7'(64 + NUM_COLS);
        endcase
    endfunction

    function automatic logic [BUS_WIDTH-1:0] hi_part(input logic [7:0] b);
        return b[7 -: BUS_WIDTH];
    endfunction

    function automatic logic [BUS_WIDTH-1:0] lo_part(input logic [7:0] b);
        return b[BUS_WIDTH-1:0];
    endfunction

    // In 4-bit mode steps 0..3 are single nibbles; 8-bit mode skips step 3.
    function automatic logic [7:0] init_byte(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h20;
            3'd4:             return FSET;
            3'd5:             return 8'h0C;
            3'd6:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    function automatic int init_us(input logic [2:0] s);
        case (s)
            3'd0:    return 4100;
            3'd1:    return 100;
            3'd6:    return 1640;
            default: return 40;
        endcase
    endfunction

    state_t               state;
    logic [31:0]          timer, wait_cyc;
    logic [7:0]           cur_byte, req_data, req_byte;
    logic [1:0]           req_func, crow;
    logic [4:0]           ccol;
    logic [2:0]           step;
    logic                 req_rs, nib_lo, single_nib, in_init, init_req, active;
    logic                 more_init, last_step, push, pop, full;
    logic [9:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          level;
`ifdef LCD_AUTO_WRAP_EN
    logic [1:0]           trk_row;
    logic [4:0]           trk_col;
    logic                 wrap_pend;
`endif

    always_comb begin
        full      = (level == (AW+1)'(FIFO_DEPTH));
        push      = i_valid && active && !full;
        more_init = in_init && (step != 3'd7);
        last_step = (state == EXEC_WAIT) && (timer == '0) && !more_init;
`ifdef LCD_AUTO_WRAP_EN
        last_step = last_step && !wrap_pend;
`endif
        pop       = (level != '0) && ((state == IDLE) || last_step);
        crow      = req_data[6:5] & 2'(NUM_ROWS - 1);
        ccol      = (req_data[4:0] > 5'(NUM_COLS - 1)) ? 5'(NUM_COLS - 1) : req_data[4:0];
        req_rs    = (req_func == 2'd3);
        req_byte  = (req_func == 2'd1) ? (8'h80 | {1'b0, row_base(crow) + 7'(ccol)}) : req_data;
    end

    assign o_ready  = active && !full;
    assign o_busy   = active && ((state != IDLE) || (level != '0));
    assign o_level  = level;
    assign o_LCD_RW = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {i_func, i_data};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= PWR_WAIT;
            timer       <= us_cycles(15_000);
            wait_cyc    <= '0;
            cur_byte    <= '0;
            req_func    <= '0;
            req_data    <= '0;
            step        <= '0;
            nib_lo      <= 1'b0;
            single_nib  <= 1'b0;
            in_init     <= 1'b0;
            init_req    <= 1'b0;
            active      <= 1'b0;
            o_LCD_DATA  <= '0;
            o_LCD_E     <= 1'b0;
            o_LCD_RS    <= 1'b0;
            o_LCD_ON    <= 1'b0;
            o_LCD_BLON  <= 1'b0;
            o_done_lcd  <= 1'b0;
            o_init_done <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
            trk_row     <= '0;
            trk_col     <= '0;
            wrap_pend   <= 1'b0;
`endif
        end else begin
            active     <= 1'b1;
            o_LCD_ON   <= i_on_lcd;
            o_LCD_BLON <= i_lcd_blon;
            o_done_lcd <= 1'b0;
            if (pop) begin
                req_func <= mem[rd_ptr][9:8];
                req_data <= mem[rd_ptr][7:0];
            end
            case (state)
                PWR_WAIT: begin
                    if (timer == '0) begin
                        state   <= INIT;
                        in_init <= 1'b1;
                        step    <= '0;
                    end else timer <= timer - 32'd1;
                end
                INIT: begin
                    cur_byte   <= init_byte(step);
                    single_nib <= FOUR && (step <= 3'd3);
                    wait_cyc   <= us_cycles(init_us(step));
                    nib_lo     <= 1'b0;
                    o_LCD_DATA <= hi_part(init_byte(step));
                    o_LCD_RS   <= 1'b0;
                    timer      <= TU - 32'd1;
                    state      <= SETUP;
                end
                IDLE: if (level != '0) state <= FETCH;
                FETCH: begin
                    if (req_func == 2'd0) begin
                        in_init     <= 1'b1;
                        init_req    <= 1'b1;
                        step        <= '0;
                        o_init_done <= 1'b0;
                        state       <= INIT;
                    end else begin
                        cur_byte   <= req_byte;
                        single_nib <= 1'b0;
                        wait_cyc   <= (!req_rs && (req_byte inside {8'h01, 8'h02, 8'h03}))
                                      ? us_cycles(1640) : us_cycles(40);
                        nib_lo     <= 1'b0;
                        o_LCD_DATA <= hi_part(req_byte);
                        o_LCD_RS   <= req_rs;
                        timer      <= TU - 32'd1;
                        state      <= SETUP;
                    end
`ifdef LCD_AUTO_WRAP_EN
                    case (req_func)
                        2'd0: begin trk_row <= '0; trk_col <= '0; end
                        2'd1: begin trk_row <= crow; trk_col <= ccol; end
                        2'd2: if (req_data inside {8'h01, 8'h02, 8'h03}) begin
                            trk_row <= '0;
                            trk_col <= '0;
                        end
                        default: if (trk_col == 5'(NUM_COLS - 1)) begin
                            wrap_pend <= 1'b1;
                            trk_row   <= (trk_row + 2'd1) & 2'(NUM_ROWS - 1);
                            trk_col   <= '0;
                        end else trk_col <= trk_col + 5'd1;
                    endcase
`endif
                end
                SETUP: begin
                    if (timer == '0) begin
                        o_LCD_E <= 1'b1;
                        timer   <= TU - 32'd1;
                        state   <= E_HIGH;
                    end else timer <= timer - 32'd1;
                end
                E_HIGH: begin
                    if (timer == '0) begin
                        o_LCD_E <= 1'b0;
                        timer   <= TU - 32'd1;
                        state   <= HOLD;
                    end else timer <= timer - 32'd1;
                end
                HOLD: begin
                    if (timer != '0) timer <= timer - 32'd1;
                    else if (FOUR && !nib_lo && !single_nib) begin
                        nib_lo     <= 1'b1;
                        o_LCD_DATA <= lo_part(cur_byte);
                        timer      <= TU - 32'd1;
                        state      <= SETUP;
                    end else begin
                        timer <= wait_cyc;
                        state <= EXEC_WAIT;
                    end
                end
                EXEC_WAIT: begin
                    if (timer != '0) timer <= timer - 32'd1;
                    else if (more_init) begin
                        step  <= (!FOUR && step == 3'd2) ? 3'd4 : step + 3'd1;
                        state <= INIT;
                    end
`ifdef LCD_AUTO_WRAP_EN
                    else if (wrap_pend) state <= WRAP;
`endif
                    else begin
                        if (in_init) begin
                            in_init     <= 1'b0;
                            init_req    <= 1'b0;
                            o_init_done <= 1'b1;
                            o_done_lcd  <= init_req;
                        end else o_done_lcd <= 1'b1;
                        state <= (level != '0) ? FETCH : IDLE;
                    end
                end
`ifdef LCD_AUTO_WRAP_EN
                WRAP: begin
                    wrap_pend  <= 1'b0;
                    cur_byte   <= 8'h80 | {1'b0, row_base(trk_row)};
                    single_nib <= 1'b0;
                    wait_cyc   <= us_cycles(40);
                    nib_lo     <= 1'b0;
                    o_LCD_DATA <= hi_part(8'h80 | {1'b0, row_base(trk_row)});
                    o_LCD_RS   <= 1'b0;
                    timer      <= TU - 32'd1;
                    state      <= SETUP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
